// File: rtl/alu_sequencer.sv
// Issue side of a 32-bit combinational ALU: accepts one op at a time, drives registered
// operands/select, captures the ALU result and returns tagged responses in order through a FIFO.
module alu_sequencer #(
  parameter int TAG_W       = 4,
  parameter int RSP_DEPTH   = 4,
  parameter int MULDIV_WAIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [3:0]       req_opcode_i,
  input  logic [31:0]      req_a_i,
  input  logic [31:0]      req_b_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic [31:0]      alu_op1_o,
  output logic [31:0]      alu_op2_o,
  output logic [2:0]       alu_sel_o,
  input  logic [31:0]      alu_result_i,
  input  logic             alu_zflag_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_result_o,
  output logic             rsp_zero_o,
  output logic             rsp_err_o,
  output logic [TAG_W-1:0] rsp_tag_o
);
  localparam int PW = $clog2(RSP_DEPTH);
  localparam int WW = (MULDIV_WAIT > 0) ? $clog2(MULDIV_WAIT + 1) : 1;
  localparam logic [PW:0] DEPTH_C = (PW+1)'(RSP_DEPTH);

  typedef enum logic {S_IDLE, S_EXEC} state_t;
  typedef enum logic [1:0] {K_NORM, K_ILL, K_DIV0} kind_t;

  state_t           r_state, w_state_nxt;
  kind_t            r_kind, w_kind;
  logic [WW-1:0]    r_wait;
  logic [TAG_W-1:0] r_tag;
  logic             w_ready, w_accept, w_push, w_pop, w_muldiv;
  logic [31:0]      w_res;
  logic             w_zero, w_err;

  logic [31:0]      r_res  [RSP_DEPTH];
  logic             r_zero [RSP_DEPTH];
  logic             r_err  [RSP_DEPTH];
  logic [TAG_W-1:0] r_tagq [RSP_DEPTH];
  logic [PW-1:0]    r_wr, r_rd;
  logic [PW:0]      r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_EXEC;
      S_EXEC:  if (r_wait == '0) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FIFO space is checked at accept, so the later push can never overflow.
  always_comb begin
    w_ready = rst_n && (r_state == S_IDLE) && (r_cnt < DEPTH_C);
    w_push  = (r_state == S_EXEC) && (r_wait == '0);
  end

  assign w_accept = req_valid_i && w_ready;
  assign w_pop    = rsp_valid_o && rsp_ready_i;

  always_comb begin
    w_kind = K_NORM;
    if (req_opcode_i[3])                                  w_kind = K_ILL;
    else if (req_opcode_i[2:0] == 3'd4 && req_b_i == '0)  w_kind = K_DIV0;
    w_muldiv = (w_kind == K_NORM) &&
               (req_opcode_i[2:0] == 3'd3 || req_opcode_i[2:0] == 3'd4);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op1_o <= '0;
      alu_op2_o <= '0;
      alu_sel_o <= '0;
      r_tag     <= '0;
      r_kind    <= K_NORM;
      r_wait    <= '0;
    end else if (w_accept) begin
      alu_op1_o <= req_a_i;
      alu_op2_o <= req_b_i;
      alu_sel_o <= (w_kind == K_ILL) ? 3'b000 : req_opcode_i[2:0];
      r_tag     <= req_tag_i;
      r_kind    <= w_kind;
      r_wait    <= w_muldiv ? WW'(MULDIV_WAIT) : '0;
    end else if (r_state == S_EXEC && r_wait != '0) begin
      r_wait <= r_wait - 1'b1;
    end
  end

  // Error entries override whatever the ALU is producing.
  always_comb begin
    w_res  = alu_result_i;
    w_zero = ~alu_zflag_i;
    w_err  = 1'b0;
    case (r_kind)
      K_ILL:   begin w_res = '0;           w_zero = 1'b0; w_err = 1'b1; end
      K_DIV0:  begin w_res = 32'hFFFF_FFFF; w_zero = 1'b0; w_err = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RSP_DEPTH; i++) begin
        r_res[i]  <= '0;
        r_zero[i] <= 1'b0;
        r_err[i]  <= 1'b0;
        r_tagq[i] <= '0;
      end
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_res[r_wr]  <= w_res;
        r_zero[r_wr] <= w_zero;
        r_err[r_wr]  <= w_err;
        r_tagq[r_wr] <= r_tag;
        r_wr         <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  assign req_ready_o  = w_ready;
  assign rsp_valid_o  = (r_cnt != '0);
  assign rsp_result_o = r_res[r_rd];
  assign rsp_zero_o   = r_zero[r_rd];
  assign rsp_err_o    = r_err[r_rd];
  assign rsp_tag_o    = r_tagq[r_rd];

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed vector table, FIFO-full and reset sequences, and a
// randomized run against an in-order response scoreboard.
module tb_alu_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [3:0]  req_opcode;
  logic [31:0] req_a, req_b;
  logic [3:0]  req_tag;
  logic [31:0] alu_op1, alu_op2, alu_result;
  logic [2:0]  alu_sel;
  logic        alu_zflag;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_err;
  logic [3:0]  rsp_tag;

  int errors = 0;
  int checks = 0;

  alu_sequencer #(.TAG_W(4), .RSP_DEPTH(4), .MULDIV_WAIT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_opcode_i(req_opcode),
    .req_a_i(req_a), .req_b_i(req_b), .req_tag_i(req_tag),
    .alu_op1_o(alu_op1), .alu_op2_o(alu_op2), .alu_sel_o(alu_sel),
    .alu_result_i(alu_result), .alu_zflag_i(alu_zflag),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result),
    .rsp_zero_o(rsp_zero), .rsp_err_o(rsp_err), .rsp_tag_o(rsp_tag)
  );

  always #5 clk = ~clk;

  // Behavioural ALU sitting on the other side of the sequencer.
  function automatic logic [31:0] alu_f(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
    case (s)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return a * b;
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd5: return a & b;
      3'd6: return a << 1;
      default: return a | b;
    endcase
  endfunction

  assign alu_result = alu_f(alu_sel, alu_op1, alu_op2);
  assign alu_zflag  = (alu_result != 0);

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // Leaves the bench #1 into the cycle after acceptance.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
    int n;
    req_valid = 1'b1; req_opcode = op; req_a = a; req_b = b; req_tag = tag;
    n = 0;
    while (!req_ready && n < 50) begin tick; n++; end
    if (!req_ready) chk("issue_timeout", 32'd1, 32'd0);
    tick;
    req_valid = 1'b0;
  endtask

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        err;
    logic [3:0]  tag;
  } exp_t;

  // Reference response from the op rules, independent of any cycle behaviour.
  function automatic exp_t ref_rsp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
    exp_t e;
    e.tag = tag;
    if (op >= 8)                  begin e.res = 0;            e.zero = 0; e.err = 1; end
    else if (op == 4 && b == 0)   begin e.res = 32'hFFFFFFFF; e.zero = 0; e.err = 1; end
    else begin
      e.res = alu_f(op[2:0], a, b); e.zero = (e.res == 0); e.err = 0;
    end
    return e;
  endfunction

  exp_t q[$];
  bit   sb_on = 0;

  always @(negedge clk) begin
    if (sb_on) begin
      if (req_valid && req_ready) q.push_back(ref_rsp(req_opcode, req_a, req_b, req_tag));
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) chk("sb_spurious", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("sb_result", rsp_result, e.res);
          chk("sb_zero", {31'd0, rsp_zero}, {31'd0, e.zero});
          chk("sb_err", {31'd0, rsp_err}, {31'd0, e.err});
          chk("sb_tag", {28'd0, rsp_tag}, {28'd0, e.tag});
        end
      end
    end
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [3:0]  tag;
    logic [31:0] res;
    logic        zero, err;
    logic [2:0]  sel;
    int          lat;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                              input logic [31:0] res, input logic zero, input logic err, input logic [2:0] sel, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.tag = tag; v.res = res;
    v.zero = zero; v.err = err; v.sel = sel; v.lat = lat;
    return v;
  endfunction

  vec_t vt[12];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    bit seen;
    vt[0]  = mk(4'd0, 5, 7, 3, 12, 0, 0, 3'b000, 2);
    vt[1]  = mk(4'd1, 9, 9, 1, 0, 1, 0, 3'b001, 2);
    vt[2]  = mk(4'd2, 2, 3, 2, 1, 0, 0, 3'b010, 2);
    vt[3]  = mk(4'd3, 6, 7, 4, 42, 0, 0, 3'b011, 4);
    vt[4]  = mk(4'd4, 100, 0, 6, 32'hFFFFFFFF, 0, 1, 3'b100, 2);
    vt[5]  = mk(4'd4, 100, 7, 7, 14, 0, 0, 3'b100, 4);
    vt[6]  = mk(4'd5, 32'hF0F0, 32'hFF00, 8, 32'hF000, 0, 0, 3'b101, 2);
    vt[7]  = mk(4'd6, 32'h80000001, 0, 9, 32'h2, 0, 0, 3'b110, 2);
    vt[8]  = mk(4'd7, 1, 2, 10, 3, 0, 0, 3'b111, 2);
    vt[9]  = mk(4'd8, 1, 2, 5, 0, 0, 1, 3'b000, 2);
    vt[10] = mk(4'd0, 0, 0, 11, 0, 1, 0, 3'b000, 2);
    vt[11] = mk(4'd2, 3, 2, 12, 0, 1, 0, 3'b010, 2);

    rst_n = 1'b1; req_valid = 0; req_opcode = 0; req_a = 0; req_b = 0; req_tag = 0; rsp_ready = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ready", {31'd0, req_ready}, 0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("rst_op1", alu_op1, 0);
    chk("rst_sel", {29'd0, alu_sel}, 0);
    chk("rst_rsp_result", rsp_result, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("post_rst_ready", {31'd0, req_ready}, 1);

    rsp_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      issue(vt[i].op, vt[i].a, vt[i].b, vt[i].tag);
      c = 1;
      while (!rsp_valid && c < 12) begin tick; c++; end
      chk($sformatf("vec%0d_latency", i), c, vt[i].lat);
      chk($sformatf("vec%0d_result", i), rsp_result, vt[i].res);
      chk($sformatf("vec%0d_zero", i), {31'd0, rsp_zero}, {31'd0, vt[i].zero});
      chk($sformatf("vec%0d_err", i), {31'd0, rsp_err}, {31'd0, vt[i].err});
      chk($sformatf("vec%0d_tag", i), {28'd0, rsp_tag}, {28'd0, vt[i].tag});
      chk($sformatf("vec%0d_sel", i), {29'd0, alu_sel}, {29'd0, vt[i].sel});
      tick;
      chk($sformatf("vec%0d_popped", i), {31'd0, rsp_valid}, 0);
    end

    // Fill the FIFO, check back-pressure, partially drain, refill across the wrap.
    rsp_ready = 1'b0;
    for (int t = 0; t < 4; t++) issue(4'd0, t, 100, 4'(t));
    tick; tick;
    chk("full_ready", {31'd0, req_ready}, 0);
    chk("full_head_tag", {28'd0, rsp_tag}, 0);
    req_valid = 1'b1; req_opcode = 0; req_a = 4; req_b = 100; req_tag = 4;
    repeat (3) tick;
    chk("full_hold_ready", {31'd0, req_ready}, 0);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      chk($sformatf("drain1_tag%0d", t), {28'd0, rsp_tag}, t);
      chk($sformatf("drain1_res%0d", t), rsp_result, 100 + t);
      tick;
    end
    rsp_ready = 1'b0;
    issue(4'd0, 4, 100, 4);
    issue(4'd0, 5, 100, 5);
    tick; tick;
    chk("refull_ready", {31'd0, req_ready}, 0);
    rsp_ready = 1'b1;
    for (int t = 2; t < 6; t++) begin
      chk($sformatf("drain2_valid%0d", t), {31'd0, rsp_valid}, 1);
      chk($sformatf("drain2_tag%0d", t), {28'd0, rsp_tag}, t);
      chk($sformatf("drain2_res%0d", t), rsp_result, 100 + t);
      tick;
    end
    chk("drain_empty", {31'd0, rsp_valid}, 0);

    // Reset in the middle of a MUL wait: nothing may come out afterwards.
    issue(4'd3, 6, 7, 9);
    tick;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ready", {31'd0, req_ready}, 0);
    chk("midrst_op1", alu_op1, 0);
    chk("midrst_op2", alu_op2, 0);
    chk("midrst_sel", {29'd0, alu_sel}, 0);
    chk("midrst_valid", {31'd0, rsp_valid}, 0);
    chk("midrst_tag", {28'd0, rsp_tag}, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    seen = 0;
    repeat (8) begin tick; if (rsp_valid) seen = 1; end
    chk("midrst_no_rsp", {31'd0, seen}, 0);
    issue(4'd0, 1, 2, 7);
    tick;
    chk("after_rst_valid", {31'd0, rsp_valid}, 1);
    chk("after_rst_result", rsp_result, 3);
    tick;

    // Randomized traffic against the scoreboard.
    sb_on = 1;
    for (int n = 0; n < 1500; n++) begin
      req_valid  = ($urandom_range(0, 3) != 0);
      req_opcode = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      req_a      = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      req_b      = ($urandom_range(0, 4) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 9)) : $urandom);
      req_tag    = 4'($urandom);
      rsp_ready  = ($urandom_range(0, 2) != 0);
      tick;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (20) tick;
    sb_on = 0;
    chk("sb_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
